// File: rtl/bank_config_writer.sv
// Configuration-bank write controller: takes a serial bitstream over valid/ready and
// writes it row by row through the BL/WL decoders with setup, pulse and hold phases.
module bank_config_writer #(
   parameter int unsigned BL_ADDR_W    = 5,
   parameter int unsigned WL_ADDR_W    = 5,
   parameter int unsigned NUM_BL       = 19,
   parameter int unsigned NUM_WL       = 19,
   parameter int unsigned PULSE_CYCLES = 1
) (
   input  logic                 prog_clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 bit_in,
   input  logic                 bit_valid,
   output logic                 bit_ready,
   output logic                 bl_enable,
   output logic [BL_ADDR_W-1:0] bl_addr,
   output logic                 bl_data,
   output logic                 wl_enable,
   output logic [WL_ADDR_W-1:0] wl_addr,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned PCNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [BL_ADDR_W-1:0] BL_LAST    = BL_ADDR_W'(NUM_BL - 1);
   localparam logic [WL_ADDR_W-1:0] WL_LAST    = WL_ADDR_W'(NUM_WL - 1);
   localparam logic [PCNT_W-1:0]    PULSE_LAST = PCNT_W'(PULSE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_DONE
   } state_t;

   state_t              state;
   logic [PCNT_W-1:0]   pulse_cnt;

   // Ready is the only output decoded straight from the state register.
   assign bit_ready = (state == S_LOAD);

   // The address registers double as the row/column counters.
   always_ff @(posedge prog_clk) begin
      if (reset) begin
         state     <= S_IDLE;
         pulse_cnt <= '0;
         bl_enable <= 1'b0;
         wl_enable <= 1'b0;
         bl_addr   <= '0;
         wl_addr   <= '0;
         bl_data   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_LOAD;
                  busy      <= 1'b1;
                  bl_addr   <= '0;
                  wl_addr   <= '0;
                  pulse_cnt <= '0;
               end
            end
            S_LOAD: begin
               if (bit_valid) begin
                  bl_data <= bit_in;
                  state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               state     <= S_PULSE;
               bl_enable <= 1'b1;
               wl_enable <= 1'b1;
               pulse_cnt <= '0;
            end
            S_PULSE: begin
               if (pulse_cnt == PULSE_LAST) begin
                  state     <= S_HOLD;
                  bl_enable <= 1'b0;
                  wl_enable <= 1'b0;
                  pulse_cnt <= '0;
               end else begin
                  pulse_cnt <= pulse_cnt + PCNT_W'(1);
               end
            end
            S_HOLD: begin
               // Addresses only move here, while both enables are already low.
               if (bl_addr != BL_LAST) begin
                  bl_addr <= bl_addr + BL_ADDR_W'(1);
                  state   <= S_LOAD;
               end else if (wl_addr != WL_LAST) begin
                  bl_addr <= '0;
                  wl_addr <= wl_addr + WL_ADDR_W'(1);
                  state   <= S_LOAD;
               end else begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               state   <= S_IDLE;
               busy    <= 1'b0;
               bl_addr <= '0;
               wl_addr <= '0;
               bl_data <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
